// File: rtl/miriscv_mem_arbiter.sv
// Two-master arbiter/sequencer for the single-ported data memory (m0 = LSU, m1 = debug/DMA).
// Define MIRISCV_ARB_FIXED_PRIO_EN for fixed m0-over-m1 priority instead of round-robin.
module miriscv_mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        arst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_done_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_done_o,
   output logic [31:0] m1_rdata_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   output logic        owner_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic        any_req, grant_sel;
   logic        req_next, we_next, owner_next, m0_done_next, m1_done_next;
   logic [3:0]  be_next;
   logic [31:0] addr_next, wdata_next, m0_rdata_next, m1_rdata_next;

   assign any_req = m0_req_i | m1_req_i;

`ifdef MIRISCV_ARB_FIXED_PRIO_EN
   // m1 only wins an IDLE cycle in which m0 is not asking
   assign grant_sel = ~m0_req_i;
`else
   logic rr_ptr;

   // rr_ptr = 0 prefers m0; a lone requester wins regardless of the pointer
   assign grant_sel = (m0_req_i & m1_req_i) ? rr_ptr : ~m0_req_i;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)
         rr_ptr <= 1'b0;
      else if (state == IDLE && any_req)
         rr_ptr <= ~grant_sel;
   end
`endif

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      req_next      = 1'b0;
      we_next       = data_we_o;
      be_next       = data_be_o;
      addr_next     = data_addr_o;
      wdata_next    = data_wdata_o;
      owner_next    = owner_o;
      m0_done_next  = 1'b0;
      m1_done_next  = 1'b0;
      m0_rdata_next = m0_rdata_o;
      m1_rdata_next = m1_rdata_o;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = ISSUE;
               req_next   = 1'b1;
               owner_next = grant_sel;
               we_next    = grant_sel ? m1_we_i    : m0_we_i;
               be_next    = grant_sel ? m1_be_i    : m0_be_i;
               addr_next  = grant_sel ? m1_addr_i  : m0_addr_i;
               wdata_next = grant_sel ? m1_wdata_i : m0_wdata_i;
            end
         end
         ISSUE: begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               state_next = DONE;
               // writes leave the owner's read data untouched
               if (!data_we_o) begin
                  if (owner_o) m1_rdata_next = data_rdata_i;
                  else         m0_rdata_next = data_rdata_i;
               end
               if (owner_o) m1_done_next = 1'b1;
               else         m0_done_next = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         data_req_o   <= 1'b0;
         data_we_o    <= 1'b0;
         data_be_o    <= 4'd0;
         data_addr_o  <= 32'd0;
         data_wdata_o <= 32'd0;
         owner_o      <= 1'b0;
         m0_done_o    <= 1'b0;
         m1_done_o    <= 1'b0;
         m0_rdata_o   <= 32'd0;
         m1_rdata_o   <= 32'd0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         data_req_o   <= req_next;
         data_we_o    <= we_next;
         data_be_o    <= be_next;
         data_addr_o  <= addr_next;
         data_wdata_o <= wdata_next;
         owner_o      <= owner_next;
         m0_done_o    <= m0_done_next;
         m1_done_o    <= m1_done_next;
         m0_rdata_o   <= m0_rdata_next;
         m1_rdata_o   <= m1_rdata_next;
      end
   end
endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Self-checking bench for miriscv_mem_arbiter: table of single transactions plus
// hand-written sequences for held requests, reset mid-WAIT and continuous contention.
module tb_miriscv_mem_arbiter;
   localparam int LAT = 3;

`ifdef MIRISCV_ARB_FIXED_PRIO_EN
   localparam logic CONTENDED = 1'b0;
`else
   localparam logic CONTENDED = 1'b1;
`endif

   logic        clk_i, arst_i;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic        m0_done_o, m1_done_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        data_req_o, data_we_o, owner_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] memData    = 32'd0;
   int          memAge     = 1000;
   logic [31:0] expRd [2];

   typedef struct {
      logic        m0Req;
      logic        m1Req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] m0Addr;
      logic [31:0] m1Addr;
      logic [31:0] wdata;
      logic [31:0] memData;
      logic        expOwner;
   } vec_t;

   vec_t vecs [8];

   miriscv_mem_arbiter #(.MEM_LATENCY(LAT)) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_done_o(m0_done_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i), .m1_done_o(m1_done_o), .m1_rdata_o(m1_rdata_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
      .owner_o(owner_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Memory model: read data is valid only in the cycle LAT cycles after the request cycle
   always @(negedge clk_i) begin
      if (data_req_o) memAge = 0;
      else if (memAge < 1000) memAge = memAge + 1;
      data_rdata_i = (memAge == LAT) ? memData : 32'hBAD0_BAD0;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      else
         passCount++;
   endtask

   task automatic applyStimulus(input vec_t v);
      m0_req_i   = v.m0Req;
      m1_req_i   = v.m1Req;
      m0_we_i    = v.we;
      m1_we_i    = v.we;
      m0_be_i    = v.be;
      m1_be_i    = ~v.be;
      m0_addr_i  = v.m0Addr;
      m1_addr_i  = v.m1Addr;
      m0_wdata_i = v.wdata;
      m1_wdata_i = ~v.wdata;
      memData    = v.memData;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_req"},   {31'd0, data_req_o}, 32'd0);
      checkOutput({tag, "_we"},    {31'd0, data_we_o}, 32'd0);
      checkOutput({tag, "_be"},    {28'd0, data_be_o}, 32'd0);
      checkOutput({tag, "_addr"},  data_addr_o, 32'd0);
      checkOutput({tag, "_wdata"}, data_wdata_o, 32'd0);
      checkOutput({tag, "_owner"}, {31'd0, owner_o}, 32'd0);
      checkOutput({tag, "_done"},  {30'd0, m1_done_o, m0_done_o}, 32'd0);
      checkOutput({tag, "_rd0"},   m0_rdata_o, 32'd0);
      checkOutput({tag, "_rd1"},   m1_rdata_o, 32'd0);
   endtask

   // One complete transaction from an IDLE cycle through DONE and back to IDLE
   task automatic runVector(input vec_t v);
      logic [31:0] expAddr, expWdata;
      logic [3:0]  expBe;
      int          earlyDone;
      expAddr  = v.expOwner ? v.m1Addr : v.m0Addr;
      expWdata = v.expOwner ? ~v.wdata : v.wdata;
      expBe    = v.expOwner ? ~v.be : v.be;
      applyStimulus(v);
      stepCycle();
      checkOutput("issue_req",   {31'd0, data_req_o}, 32'd1);
      checkOutput("issue_owner", {31'd0, owner_o}, {31'd0, v.expOwner});
      checkOutput("issue_we",    {31'd0, data_we_o}, {31'd0, v.we});
      checkOutput("issue_be",    {28'd0, data_be_o}, {28'd0, expBe});
      checkOutput("issue_addr",  data_addr_o, expAddr);
      checkOutput("issue_wdata", data_wdata_o, expWdata);
      // attributes change mid-transaction; the latched ones must survive
      m0_addr_i = 32'hFFFF_FFF0; m1_addr_i = 32'hFFFF_FFF4;
      m0_wdata_i = 32'd0; m1_wdata_i = 32'd0; m0_be_i = 4'd0; m1_be_i = 4'd0;
      m0_we_i = ~v.we; m1_we_i = ~v.we;
      earlyDone = 0;
      for (int k = 2; k <= 2 + LAT; k++) begin
         stepCycle();
         if (k < 2 + LAT) earlyDone += int'(m0_done_o) + int'(m1_done_o) + int'(data_req_o);
      end
      if (!v.we) expRd[v.expOwner] = v.memData;
      checkOutput("wait_quiet",   earlyDone, 32'd0);
      checkOutput("done_m0",      {31'd0, m0_done_o}, {31'd0, ~v.expOwner});
      checkOutput("done_m1",      {31'd0, m1_done_o}, {31'd0, v.expOwner});
      checkOutput("done_rdata0",  m0_rdata_o, expRd[0]);
      checkOutput("done_rdata1",  m1_rdata_o, expRd[1]);
      checkOutput("done_addr",    data_addr_o, expAddr);
      checkOutput("done_we",      {31'd0, data_we_o}, {31'd0, v.we});
      m0_req_i = 1'b0;
      m1_req_i = 1'b0;
      stepCycle();
      checkOutput("idle_done",  {30'd0, m1_done_o, m0_done_o}, 32'd0);
      checkOutput("idle_req",   {31'd0, data_req_o}, 32'd0);
      checkOutput("idle_addr",  data_addr_o, expAddr);
      checkOutput("idle_wdata", data_wdata_o, expWdata);
   endtask

   initial begin
      int   doneCount, grants, lastGrant, ownerIdx;
      logic prevDone, finished;
      logic expOwnerC [5];
      vec_t v;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 4'hC, 32'h0,         32'h0000_0020, 32'hEDCB_A987, 32'h0BAD_CAFE, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0000_0200, 32'h0,         32'hA5A5_0001, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0104, 32'h0000_0204, 32'h0,         32'h5A5A_0002, CONTENDED};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h3, 32'h0,         32'h0000_0300, 32'h0,         32'h0000_0303, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0400, 32'h0000_0404, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 4'h1, 32'h0000_0500, 32'h0,         32'h0,         32'h1111_2222, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0000_0604, 32'h0,         32'h3333_4444, CONTENDED};

      m0_req_i = 0; m0_we_i = 0; m0_be_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
      m1_req_i = 0; m1_we_i = 0; m1_be_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
      expRd[0] = 32'd0;
      expRd[1] = 32'd0;
      arst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checkAllZero("reset");
      arst_i = 1'b0;

      for (int i = 0; i < 8; i++) runVector(vecs[i]);

      // m0 holds req through its DONE cycle: re-granted from the following IDLE cycle
      v = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0800, 32'h0, 32'h0, 32'h8888_0008, 1'b0};
      applyStimulus(v);
      doneCount = 0;
      for (int c = 1; c <= LAT + 4; c++) begin
         stepCycle();
         doneCount += int'(m0_done_o) + int'(m1_done_o);
         if (c == LAT + 3) checkOutput("held_idle_req", {31'd0, data_req_o}, 32'd0);
      end
      checkOutput("held_regrant",   {31'd0, data_req_o}, 32'd1);
      checkOutput("held_done_once", doneCount, 32'd1);
      checkOutput("held_rdata",     m0_rdata_o, 32'h8888_0008);
      m0_req_i = 1'b0;
      doneCount = 0;
      for (int c = 0; c < LAT + 4 && doneCount == 0; c++) begin
         stepCycle();
         doneCount += int'(m0_done_o);
      end
      checkOutput("held_second_done", doneCount, 32'd1);
      stepCycle();

      // Reset while in WAIT aborts the transaction with no done pulse
      v = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0900, 32'h0, 32'h0, 32'h9999_0009, 1'b0};
      applyStimulus(v);
      stepCycle();
      stepCycle();
      arst_i = 1'b1;
      #1;
      checkAllZero("midrst");
      m0_req_i = 1'b0;
      doneCount = 0;
      repeat (2) begin
         stepCycle();
         doneCount += int'(m0_done_o) + int'(m1_done_o);
      end
      arst_i = 1'b0;
      expRd[0] = 32'd0;
      expRd[1] = 32'd0;
      for (int c = 0; c < LAT + 3; c++) begin
         stepCycle();
         doneCount += int'(m0_done_o) + int'(m1_done_o) + int'(data_req_o);
      end
      checkOutput("midrst_no_done", doneCount, 32'd0);
      v = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_0A00, 32'h0, 32'hAAAA_000A, 1'b1};
      runVector(v);

      // Continuous contention; m0 drops out after the 4th completion so m1 wins alone
      expOwnerC[0] = 1'b0;
      expOwnerC[1] = CONTENDED;
      expOwnerC[2] = 1'b0;
      expOwnerC[3] = CONTENDED;
      expOwnerC[4] = 1'b1;
      m0_req_i = 1'b1; m1_req_i = 1'b1; m0_we_i = 1'b0; m1_we_i = 1'b0;
      m0_addr_i = 32'h0000_0B00; m1_addr_i = 32'h0000_0C00;
      grants = 0; lastGrant = 0; prevDone = 1'b0; finished = 1'b0;
      for (int c = 1; c < 6 * (LAT + 3) + 10 && !finished; c++) begin
         stepCycle();
         if (data_req_o) begin
            ownerIdx = (grants < 5) ? grants : 4;
            if (grants > 0) checkOutput("contend_spacing", c - lastGrant, LAT + 3);
            checkOutput("contend_owner", {31'd0, owner_o}, {31'd0, expOwnerC[ownerIdx]});
            lastGrant = c;
            grants++;
         end
         if (m0_done_o | m1_done_o) begin
            checkOutput("contend_pulse_width", {31'd0, prevDone}, 32'd0);
            checkOutput("contend_done_owner", {31'd0, m1_done_o}, {31'd0, owner_o});
            if (grants == 4) m0_req_i = 1'b0;
            if (grants >= 5) begin
               m1_req_i = 1'b0;
               finished = 1'b1;
            end
         end
         prevDone = m0_done_o | m1_done_o;
      end
      checkOutput("contend_grants", grants, 32'd5);
      stepCycle();
      checkOutput("contend_final_idle", {30'd0, m1_done_o, data_req_o}, 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported data memory.
- Shares the data memory between master 0 (core LSU) and master 1 (debug/DMA port).
- Sequences each access as: registered request cycle, fixed-latency wait, one-cycle completion pulse to the owning master.
- Sits between the masters' request ports and the memory's data_* protocol.

Parameters:
- MEM_LATENCY, 1, cycles from the memory request cycle to valid data_rdata_i (legal 1..15).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- m0_req_i  in  1  master 0 request; held with stable attributes until m0_done_o.
- m0_we_i  in  1  master 0: 1 = write, 0 = read.
- m0_be_i  in  4  master 0 byte enables.
- m0_addr_i  in  32  master 0 address.
- m0_wdata_i  in  32  master 0 write data.
- m0_done_o  out  1  one-cycle completion pulse to master 0.
- m0_rdata_o  out  32  read data to master 0; valid from its done cycle, held until next read completes.
- m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, m1_done_o, m1_rdata_o: same as master 0, for master 1.
- data_req_o  out  1  memory request.
- data_we_o  out  1  memory write enable.
- data_be_o  out  4  memory byte enables.
- data_addr_o  out  32  memory address.
- data_wdata_o  out  32  memory write data.
- data_rdata_i  in  32  memory read data.
- owner_o  out  1  master owning the current or last transaction.

Behaviour:
Reset (arst_i=1), effective immediately:
- All outputs go to 0.
- State = IDLE; round-robin pointer prefers m0.
- Reset mid-transaction aborts it: no done pulse, counter cleared.

State machine, all outputs registered:
- IDLE:
  - No req: stay.
  - Any req: pick winner, set owner_o, latch winner's we/be/addr/wdata onto data_*; data_req_o<=1; go to ISSUE.
- ISSUE: data_req_o=1 for exactly this cycle. On exit: data_req_o<=0, cnt<=MEM_LATENCY-1; go to WAIT.
- WAIT:
  - cnt!=0: cnt decrements.
  - cnt==0: for a read, capture data_rdata_i into mX_rdata_o of the owner; owner's done<=1; go to DONE.
  - A write leaves mX_rdata_o unchanged.
- DONE:
  - Owner's done_o=1 for this cycle only. Next state IDLE; done<=0.
  - Requests are ignored in DONE.
  - A req still high in the following IDLE cycle is a new transaction.

Latency:
- req seen in IDLE at cycle 0 → data_req_o in cycle 1, data_rdata_i sampled in cycle 1+MEM_LATENCY, done_o in cycle 2+MEM_LATENCY.
- Minimum gap between two grants: MEM_LATENCY+3 cycles.

Arbitration (round-robin):
- Single requester wins regardless of pointer.
- Both requesting in IDLE: pointer's preferred master wins.
- After any grant, pointer prefers the other master.

data_we_o/be_o/addr_o/wdata_o:
- Hold the latched values from ISSUE through DONE and stay unchanged in IDLE; they are only updated on a new grant.

Protocol violations:
- A master dropping req or changing attributes mid-transaction has no effect; the transaction completes with the latched values and done still pulses.

Widths: pure pass-through; no alignment or extension (handled by the LSU).

Optional Feature:
- MIRISCV_ARB_FIXED_PRIO_EN defined:
  - m0 always wins simultaneous requests; the pointer is not implemented.
  - m1 is served only in an IDLE cycle with m0_req_i=0.
- Undefined: round-robin as above.

Test Plan:
1. Single read, MEM_LATENCY=1: m0 read addr 0x0000_0010, memory returns 0xDEAD_BEEF.
   → data_req_o high in cycle 1 only, data_addr_o=0x10, data_we_o=0; m0_done_o in cycle 3 with m0_rdata_o=0xDEAD_BEEF; m1_done_o stays 0.
2. Single write, MEM_LATENCY=3: m1 write addr 0x20, be 4'b0011, wdata 0x1234_5678.
   → data_req_o in cycle 1, data_we_o=1, data_be_o=4'b0011; m1_done_o in cycle 5; m1_rdata_o unchanged.
3. Contention, round-robin: m0 and m1 request continuously from reset, reads.
   → grant order m0, m1, m0, m1; owner_o alternates; grants spaced MEM_LATENCY+3 cycles; each done pulse is 1 cycle.
4. Held req across DONE: m0 keeps req high through its done cycle, m1 idle.
   → second m0 grant starts in the IDLE cycle after DONE (data_req_o at cycle 5 for MEM_LATENCY=1), with no duplicate done.
5. Reset mid-WAIT, MEM_LATENCY=4: assert arst_i during WAIT.
   → all outputs 0 immediately; no done pulse; after release, m1 requesting alone wins and pointer prefers m0.
6. MIRISCV_ARB_FIXED_PRIO_EN defined, both requesting continuously.
   → m0 wins every grant; m1 is granted only after m0 deasserts req in an IDLE cycle.
